mc_control_fsm: RTL and testbench

Main control state machine for the multicycle MIPS datapath. Decodes the instruction register opcode/funct and steps each instruction through fetch, decode, execute, memory and write-back, driving every datapath mux select, the write enables and the ALU-op class. Sits beside the datapath; its `alu_src_b` output drives the ALU source-B mux directly (0 = B register, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted branch offset). Waits on a memory ready handshake for every memory access.

---
 rtl/mc_control_pkg.sv | 76 +++++++
 rtl/mc_control_fsm_if.sv | 47 ++++
 rtl/mc_control_decode.sv | 81 ++++++++
 rtl/mc_control_fsm.sv | 98 +++++++++
 tb/tb_mc_control_fsm.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Optional exception support is selected with MC_EXCEPTION_EN.
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_EXCEPT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_BOFF  = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic CAUSE_OPCODE = 1'b0;
  localparam logic CAUSE_FUNCT  = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
`ifdef MC_EXCEPTION_EN
    logic       epc_write;
    logic       cause_write;
`endif
  } ctrl_t;

  function automatic logic funct_defined(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
// MC_EXCEPTION_EN adds the EPC/Cause register controls.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
`ifdef MC_EXCEPTION_EN
  logic       epc_write;
  logic       cause_write;
  logic       int_cause;
`endif

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state
`ifdef MC_EXCEPTION_EN
    , output epc_write, cause_write, int_cause
`endif
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state
`ifdef MC_EXCEPTION_EN
    , input epc_write, cause_write, int_cause
`endif
  );
endinterface

// File: rtl/mc_control_decode.sv
// Combinational state -> control-vector decode (pure Moore part of the FSM).
// MC_EXCEPTION_EN adds the EXCEPT state decode.
module mc_control_decode
  import mc_control_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  // FETCH ir_write/pc_write are left 0 here; the top gates them with mem_ready.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_BOFF;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
`ifdef MC_EXCEPTION_EN
      S_EXCEPT: begin
        o_ctrl.epc_write   = 1'b1;
        o_ctrl.cause_write = 1'b1;
        o_ctrl.pc_write    = 1'b1;
        o_ctrl.pc_source   = PCSRC_EXC;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic, output gating.
// Define MC_EXCEPTION_EN to trap undefined opcodes / R-type functs into EXCEPT.
module mc_control_fsm
  import mc_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_control_fsm_if.master   bus
);

  state_t r_state;
  ctrl_t  w_ctrl;
  logic   w_mem_ok;
  logic   w_fetch_done;
  logic   w_unused;

  assign w_mem_ok     = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  // rst_n gate keeps the fetch strobes quiet while reset is held.
  assign w_fetch_done = (r_state == S_FETCH) && w_mem_ok && rst_n;
  assign w_unused     = ^{bus.funct, bus.zero, bus.mem_ready};

`ifdef MC_EXCEPTION_EN
  logic r_cause;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
`ifdef MC_EXCEPTION_EN
      r_cause <= CAUSE_OPCODE;
`endif
    end else begin
      case (r_state)
        S_FETCH:     if (w_mem_ok) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_RTYPE: begin
`ifdef MC_EXCEPTION_EN
              if (!funct_defined(bus.funct)) begin
                r_state <= S_EXCEPT;
                r_cause <= CAUSE_FUNCT;
              end else
`endif
              r_state <= S_R_EXEC;
            end
            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            OP_ADDI:      r_state <= S_ADDI_EXEC;
            default: begin
`ifdef MC_EXCEPTION_EN
              r_state <= S_EXCEPT;
              r_cause <= CAUSE_OPCODE;
`else
              r_state <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEM_ADDR:  r_state <= (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (w_mem_ok) r_state <= S_MEM_WB;
        S_MEM_WRITE: if (w_mem_ok) r_state <= S_FETCH;
        S_R_EXEC:    r_state <= S_R_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  mc_control_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign bus.pc_write      = w_ctrl.pc_write | w_fetch_done;
  assign bus.ir_write      = w_ctrl.ir_write | w_fetch_done;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.i_or_d        = w_ctrl.i_or_d;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.state         = r_state;

`ifdef MC_EXCEPTION_EN
  assign bus.epc_write   = w_ctrl.epc_write;
  assign bus.cause_write = w_ctrl.cause_write;
  assign bus.int_cause   = (r_state == S_EXCEPT) && r_cause;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm against an instruction-level phase model.
// Honors MC_EXCEPTION_EN when the design is built with it.
module tb_mc_control_fsm;
  import mc_control_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] seq[$];
`ifdef MC_EXCEPTION_EN
  logic exp_cause;
`endif

  mc_control_fsm_if bus ();

  mc_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_ctrl();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  // Expected control word for each phase, straight from the per-state table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] ph, input logic rdy);
    logic pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    pcw = 0; pcwc = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0; sa = 0;
    sb = 0; op = 0; ps = 0;
    case (ph)
      4'd0:  begin mr = 1; sb = 1; irw = rdy; pcw = rdy; end
      4'd1:  sb = 3;
      4'd2:  begin sa = 1; sb = 2; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin sa = 1; op = 2; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; op = 1; pcwc = 1; ps = 1; end
      4'd9:  begin pcw = 1; ps = 2; end
      4'd10: begin sa = 1; sb = 2; end
      4'd11: rw = 1;
      4'd12: begin pcw = 1; ps = 3; end
      default: ;
    endcase
    return {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  // Phase list an instruction walks through, from opcode/funct alone.
  task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
    seq = '{4'd0, 4'd1};
    case (op)
      6'h00: begin
`ifdef MC_EXCEPTION_EN
        if (!(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
          seq.push_back(4'd12); exp_cause = 1'b1;
        end else
`endif
        begin seq.push_back(4'd6); seq.push_back(4'd7); end
      end
      6'h23: begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
      6'h2B: begin seq.push_back(4'd2); seq.push_back(4'd5); end
      6'h04: seq.push_back(4'd8);
      6'h02: seq.push_back(4'd9);
      6'h08: begin seq.push_back(4'd10); seq.push_back(4'd11); end
      default: begin
`ifdef MC_EXCEPTION_EN
        seq.push_back(4'd12); exp_cause = 1'b0;
`endif
      end
    endcase
    if (fn == 6'h3F && op == 6'h3E) seq.push_back(4'd15);
  endtask

  task automatic step(input logic [3:0] ph, input logic rdy);
    bus.mem_ready = rdy;
    bus.zero      = 1'($urandom);
    #2;
    chk($sformatf("state@%0d", ph), 32'(bus.state), 32'(ph));
    chk($sformatf("ctrl@%0d", ph), 32'(get_ctrl()), 32'(exp_ctrl(ph, rdy)));
`ifdef MC_EXCEPTION_EN
    chk($sformatf("exc@%0d", ph), 32'({bus.epc_write, bus.cause_write, bus.int_cause}),
        (ph == 4'd12) ? 32'({2'b11, exp_cause}) : 32'd0);
`endif
    @(negedge clk);
  endtask

  // wait arguments: -1 picks a random number of not-ready cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_wait, input int mem_wait);
    int nw;
    build_seq(op, fn);
    bus.opcode = op;
    bus.funct  = fn;
    foreach (seq[i]) begin
      if (seq[i] == 4'd0 || seq[i] == 4'd3 || seq[i] == 4'd5) begin
        nw = (seq[i] == 4'd0) ? fetch_wait : mem_wait;
        if (nw < 0) nw = int'($urandom_range(0, 3));
        repeat (nw) step(seq[i], 1'b0);
        step(seq[i], 1'b1);
      end else begin
        step(seq[i], 1'($urandom));
      end
    end
  endtask

  logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h01, 6'h0F};
  logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    logic [5:0] op, fn;
    rst_n         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
`ifdef MC_EXCEPTION_EN
    exp_cause = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    // reset held with mem_ready high: FETCH decode, strobes suppressed
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_ctrl", 32'(get_ctrl()), 32'(exp_ctrl(4'd0, 1'b0)));
    rst_n = 1'b1;

    run_instr(6'h23, 6'h20, 0, 0);   // lw, ready high
    run_instr(6'h2B, 6'h20, 0, 3);   // sw, three wait cycles
    run_instr(6'h04, 6'h20, 0, 0);   // beq
    run_instr(6'h04, 6'h20, 0, 0);
    run_instr(6'h08, 6'h20, 2, 0);   // addi after two fetch waits
    run_instr(6'h3F, 6'h20, 0, 0);   // undefined opcode
    run_instr(6'h00, 6'h22, 0, 0);   // R-type sub

    // async reset in the middle of MEM_READ
    bus.opcode = 6'h23;
    step(4'd0, 1'b1);
    step(4'd1, 1'b0);
    step(4'd2, 1'b0);
    bus.mem_ready = 1'b0;
    #2;
    chk("pre_rst_state", 32'(bus.state), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_regw", 32'(bus.reg_write), 32'd0);
    bus.mem_ready = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'(get_ctrl()), 32'(exp_ctrl(4'd0, 1'b0)));
    @(negedge clk);
    chk("held_rst_state", 32'(bus.state), 32'd0);
    rst_n = 1'b1;
    run_instr(6'h23, 6'h20, 1, 1);

    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 8)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
